// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_stage
// Description : RV32I/RV32E instruction-decode stage. Holds the architectural
//               register file (with optional write-back bypass), decodes the
//               incoming instruction, sign-extends its immediate and registers
//               the results into the ID/EX pipeline register. Valid/ready
//               handshake on both sides; one bubble on load-use hazards.
// Revision    : 1.0 - initial release
// ============================================================================
module id_stage #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int BYPASS   = 1
) (
  input  logic            clk,
  input  logic            rst,
  // IF side
  input  logic            if_valid_i,
  output logic            if_ready_o,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            flush_i,
  // write-back port
  input  logic            wb_we_i,
  input  logic [4:0]      wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  // EX side
  output logic            id_valid_o,
  input  logic            ex_ready_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  output logic [XLEN-1:0] imm_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [4:0]      rd_o,
  output logic [6:0]      opcode_o,
  output logic [2:0]      funct3_o,
  output logic [6:0]      funct7_o,
  output logic            illegal_o
);

  // Register index width, derived from the register count.
  localparam int RAW = $clog2(NUM_REGS);

  // RV32I base opcodes.
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_IMM    = 7'b0010011;
  localparam logic [6:0] c_OP_REG    = 7'b0110011;
  localparam logic [6:0] c_OP_FENCE  = 7'b0001111;
  localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;

  // --------------------------------------------------------------------------
  // Instruction fields
  // --------------------------------------------------------------------------
  logic [6:0] w_opcode;
  logic [4:0] w_rd;
  logic [2:0] w_funct3;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic [6:0] w_funct7;

  assign w_opcode = instr_i[6:0];
  assign w_rd     = instr_i[11:7];
  assign w_funct3 = instr_i[14:12];
  assign w_rs1    = instr_i[19:15];
  assign w_rs2    = instr_i[24:20];
  assign w_funct7 = instr_i[31:25];

  // --------------------------------------------------------------------------
  // Decode
  // --------------------------------------------------------------------------
  logic            w_fmt_i;
  logic            w_fmt_s;
  logic            w_fmt_b;
  logic            w_fmt_u;
  logic            w_fmt_j;
  logic            w_op_known;
  logic            w_rs1_used;
  logic            w_rs2_used;
  logic            w_rd_used;
  logic            w_e_bad;
  logic            w_illegal;
  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm;

  // Classify the opcode into its immediate format and check it is known.
  always_comb begin
    w_fmt_i    = 1'b0;
    w_fmt_s    = 1'b0;
    w_fmt_b    = 1'b0;
    w_fmt_u    = 1'b0;
    w_fmt_j    = 1'b0;
    w_op_known = 1'b1;
    case (w_opcode)
      c_OP_IMM, c_OP_LOAD, c_OP_JALR, c_OP_SYSTEM: w_fmt_i = 1'b1;
      c_OP_STORE:                                  w_fmt_s = 1'b1;
      c_OP_BRANCH:                                 w_fmt_b = 1'b1;
      c_OP_LUI, c_OP_AUIPC:                        w_fmt_u = 1'b1;
      c_OP_JAL:                                    w_fmt_j = 1'b1;
      c_OP_REG, c_OP_FENCE:                        w_op_known = 1'b1;
      default:                                     w_op_known = 1'b0;
    endcase
  end

  // Assemble the 32-bit immediate for the detected format.
  always_comb begin
    w_imm32 = '0;
    if (w_fmt_i) begin
      w_imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
    end else if (w_fmt_s) begin
      w_imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    end else if (w_fmt_b) begin
      w_imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                 instr_i[30:25], instr_i[11:8], 1'b0};
    end else if (w_fmt_u) begin
      w_imm32 = {instr_i[31:12], 12'b0};
    end else if (w_fmt_j) begin
      w_imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                 instr_i[20], instr_i[30:21], 1'b0};
    end
  end

  // Extend to the datapath width keeping the sign.
  assign w_imm = XLEN'($signed(w_imm32));

  // Register operand usage: U/J carry no sources, I carries only rs1, and
  // stores/branches do not write a destination.
  assign w_rs1_used = !(w_fmt_u || w_fmt_j);
  assign w_rs2_used = !(w_fmt_i || w_fmt_u || w_fmt_j);
  assign w_rd_used  = !(w_fmt_s || w_fmt_b);

  // RV32E only has x0..x15, so any used index with bit 4 set is illegal.
  assign w_e_bad = (NUM_REGS == 16) &&
                   ((w_rs1_used && w_rs1[4]) ||
                    (w_rs2_used && w_rs2[4]) ||
                    (w_rd_used  && w_rd[4]));

  assign w_illegal = !w_op_known || (instr_i[1:0] != 2'b11) || w_e_bad;

  // --------------------------------------------------------------------------
  // Register file
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] r_rf [NUM_REGS];
  logic            w_wb_fire;
  logic [4:0]      w_src_idx  [2];
  logic [XLEN-1:0] w_src_data [2];

  assign w_wb_fire = wb_we_i && (wb_rd_i != 5'd0) && (int'(wb_rd_i) < NUM_REGS);

  // Write-back into the register file; x0 is never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_rf[i] <= '0;
      end
    end else if (w_wb_fire) begin
      r_rf[wb_rd_i[RAW-1:0]] <= wb_data_i;
    end
  end

  assign w_src_idx[0] = w_rs1;
  assign w_src_idx[1] = w_rs2;

  // Combinational source reads: x0 and out-of-range indices read 0, and a
  // same-cycle write-back to the source is forwarded when bypass is enabled.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_src_data[p] = '0;
      if ((w_src_idx[p] != 5'd0) && (int'(w_src_idx[p]) < NUM_REGS)) begin
        if ((BYPASS != 0) && wb_we_i && (wb_rd_i == w_src_idx[p])) begin
          w_src_data[p] = wb_data_i;
        end else begin
          w_src_data[p] = r_rf[w_src_idx[p][RAW-1:0]];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Handshake and load-use hazard
  // --------------------------------------------------------------------------
  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_rs1_data;
  logic [XLEN-1:0] r_rs2_data;
  logic [XLEN-1:0] r_imm;
  logic [4:0]      r_rs1;
  logic [4:0]      r_rs2;
  logic [4:0]      r_rd;
  logic [6:0]      r_opcode;
  logic [2:0]      r_funct3;
  logic [6:0]      r_funct7;
  logic            r_illegal;
  logic            w_load_en;
  logic            w_hazard;

  assign w_load_en = !r_valid || ex_ready_i;

  // A load sitting in ID/EX whose destination feeds a source of the incoming
  // instruction cannot be forwarded in time, so one bubble is inserted.
  assign w_hazard = r_valid && (r_opcode == c_OP_LOAD) && (r_rd != 5'd0) &&
                    ((w_rs1_used && (w_rs1 == r_rd)) ||
                     (w_rs2_used && (w_rs2 == r_rd)));

  assign if_ready_o = w_load_en && !w_hazard;

  // ID/EX pipeline register: flush squashes, a hazard bubbles, otherwise an
  // accepted instruction loads when EX can take the current contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_opcode   <= '0;
      r_funct3   <= '0;
      r_funct7   <= '0;
      r_illegal  <= 1'b0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
    end else if (w_load_en) begin
      if (w_hazard) begin
        r_valid <= 1'b0;
      end else begin
        r_valid <= if_valid_i;
        if (if_valid_i) begin
          r_pc       <= pc_i;
          r_rs1_data <= w_src_data[0];
          r_rs2_data <= w_src_data[1];
          r_imm      <= w_imm;
          r_rs1      <= w_rs1;
          r_rs2      <= w_rs2;
          r_rd       <= w_rd;
          r_opcode   <= w_opcode;
          r_funct3   <= w_funct3;
          r_funct7   <= w_funct7;
          r_illegal  <= w_illegal;
        end
      end
    end
  end

  assign id_valid_o = r_valid;
  assign pc_o       = r_pc;
  assign rs1_data_o = r_rs1_data;
  assign rs2_data_o = r_rs2_data;
  assign imm_o      = r_imm;
  assign rs1_o      = r_rs1;
  assign rs2_o      = r_rs2;
  assign rd_o       = r_rd;
  assign opcode_o   = r_opcode;
  assign funct3_o   = r_funct3;
  assign funct7_o   = r_funct7;
  assign illegal_o  = r_illegal;

endmodule
`default_nettype wire
